// File: rtl/scan_chain_ctrl_if.sv
// Handshake and scan-chain signals between the pattern source, scan_chain_ctrl and the sdff chain.
// Optional SCAN_CTRL_COMPARE_EN adds expected/mask inputs and the fail result.
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] response_out;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] expected_in;
  logic [CHAIN_LEN-1:0] mask_in;
  logic                 fail;

  modport master (
    output start, pattern_in, SO, expected_in, mask_in,
    input  SE, SI, busy, done, response_out, fail
  );
  modport slave (
    input  start, pattern_in, SO, expected_in, mask_in,
    output SE, SI, busy, done, response_out, fail
  );
`else
  modport master (
    output start, pattern_in, SO,
    input  SE, SI, busy, done, response_out
  );
  modport slave (
    input  start, pattern_in, SO,
    output SE, SI, busy, done, response_out
  );
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// Sequences one scan test (shift-in, capture, shift-out) over a CHAIN_LEN sdff chain.
// Define SCAN_CTRL_COMPARE_EN to add masked comparison of the response against an expected word.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN   = 8,
  parameter int unsigned CAPTURE_CYC = 1
) (
  input logic              CLK,
  input logic              R,
  scan_chain_ctrl_if.slave bus
);
  localparam int unsigned CntW = ($clog2(CHAIN_LEN + 1) < 1) ? 1 : $clog2(CHAIN_LEN + 1);
  localparam int unsigned CapW = ($clog2(CAPTURE_CYC + 1) < 1) ? 1 : $clog2(CAPTURE_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN);
  localparam logic [CapW-1:0] CapLast = CapW'(CAPTURE_CYC);

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StCapture,
    StShiftOut,
    StDone
  } state_e;

  state_e               state_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic [CapW-1:0]      cap_cnt_q;
  logic [CHAIN_LEN-1:0] shadow_q;
  logic [CHAIN_LEN-1:0] resp_sh_q;
  logic [CHAIN_LEN-1:0] resp_q;
  logic [CHAIN_LEN-1:0] resp_next;
  logic                 se_q;
  logic                 si_q;
  logic                 done_q;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic                 fail_q;
`endif

  // First SO sample ends up in the MSB after CHAIN_LEN shifts (tail cell first).
  assign resp_next = (resp_sh_q << 1) | CHAIN_LEN'(bus.SO);

  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      cap_cnt_q <= '0;
      shadow_q  <= '0;
      resp_sh_q <= '0;
      resp_q    <= '0;
      se_q      <= 1'b0;
      si_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
      exp_q     <= '0;
      mask_q    <= '0;
      fail_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          se_q   <= 1'b0;
          si_q   <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            // MSB goes out now; the shadow keeps the remaining bits MSB-aligned.
            si_q      <= bus.pattern_in[CHAIN_LEN-1];
            shadow_q  <= bus.pattern_in << 1;
            se_q      <= 1'b1;
            bit_cnt_q <= CntW'(1);
            state_q   <= StShiftIn;
`ifdef SCAN_CTRL_COMPARE_EN
            exp_q     <= bus.expected_in;
            mask_q    <= bus.mask_in;
`endif
          end
        end
        StShiftIn: begin
          if (bit_cnt_q == CntLast) begin
            se_q      <= 1'b0;
            si_q      <= 1'b0;
            cap_cnt_q <= CapW'(1);
            state_q   <= StCapture;
          end else begin
            si_q      <= shadow_q[CHAIN_LEN-1];
            shadow_q  <= shadow_q << 1;
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StCapture: begin
          if (cap_cnt_q == CapLast) begin
            se_q      <= 1'b1;
            si_q      <= 1'b0;
            bit_cnt_q <= CntW'(1);
            state_q   <= StShiftOut;
          end else begin
            cap_cnt_q <= cap_cnt_q + CapW'(1);
          end
        end
        StShiftOut: begin
          resp_sh_q <= resp_next;
          if (bit_cnt_q == CntLast) begin
            se_q    <= 1'b0;
            done_q  <= 1'b1;
            resp_q  <= resp_next;
            state_q <= StDone;
`ifdef SCAN_CTRL_COMPARE_EN
            fail_q  <= |((resp_next ^ exp_q) & ~mask_q);
`endif
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.SE           = se_q;
  assign bus.SI           = si_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = done_q;
  assign bus.response_out = resp_q;
`ifdef SCAN_CTRL_COMPARE_EN
  assign bus.fail         = fail_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: inverting sdff chains, random patterns, response predicted from pattern.
// Compare checks are enabled when SCAN_CTRL_COMPARE_EN is defined.
module tb_scan_chain_ctrl;
  localparam int NA    = 4;
  localparam int CA    = 1;
  localparam int DoneA = 2 * NA + CA + 1;
  localparam int DoneB = 2 * 4 + 3 + 1;
  localparam int DoneC = 2 * 1 + 1 + 1;

  logic clk = 1'b0;
  logic r   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] last_resp_a = 4'b0000;
`ifdef SCAN_CTRL_COMPARE_EN
  logic [3:0] cmp_exp  = 4'b0000;
  logic [3:0] cmp_mask = 4'b0000;
  logic       last_fail_a = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus_a ();
  scan_chain_ctrl_if #(.CHAIN_LEN(4)) bus_b ();
  scan_chain_ctrl_if #(.CHAIN_LEN(1)) bus_c ();

  scan_chain_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYC(1)) dut_a (.CLK(clk), .R(r), .bus(bus_a));
  scan_chain_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYC(3)) dut_b (.CLK(clk), .R(r), .bus(bus_b));
  scan_chain_ctrl #(.CHAIN_LEN(1), .CAPTURE_CYC(1)) dut_c (.CLK(clk), .R(r), .bus(bus_c));

  // sdff chains: SE=1 shifts SI in at cell 0, SE=0 loads D = ~Q.
  logic [3:0] chain_a = 4'b0000;
  logic [3:0] chain_b = 4'b0000;
  logic       chain_c = 1'b0;
  always @(posedge clk) chain_a <= bus_a.SE ? {chain_a[2:0], bus_a.SI} : ~chain_a;
  always @(posedge clk) chain_b <= bus_b.SE ? {chain_b[2:0], bus_b.SI} : ~chain_b;
  always @(posedge clk) chain_c <= bus_c.SE ? bus_c.SI : ~chain_c;
  assign bus_a.SO = chain_a[3];
  assign bus_b.SO = chain_b[3];
  assign bus_c.SO = chain_c;

  // Full test on dut_a with cycle-exact checks; optionally a second start while busy.
  task automatic run_a(input logic [3:0] p, input int extra_cyc, input logic [3:0] extra_p,
                       input string name);
    logic [3:0] exp_resp;
    logic [3:0] si_sh;
    logic [3:0] exp_r;
    logic       exp_se, exp_si, exp_busy, exp_done;
    int         done_cnt;
    exp_resp = (CA % 2 == 1) ? ~p : p;
    si_sh    = p;
    done_cnt = 0;
    @(negedge clk);
    bus_a.start      = 1'b1;
    bus_a.pattern_in = p;
`ifdef SCAN_CTRL_COMPARE_EN
    bus_a.expected_in = cmp_exp;
    bus_a.mask_in     = cmp_mask;
`endif
    @(posedge clk);
    #1;
    for (int k = 1; k <= DoneA + 1; k++) begin
      bus_a.start      = (k == extra_cyc);
      bus_a.pattern_in = (k == extra_cyc) ? extra_p : 4'($urandom);
`ifdef SCAN_CTRL_COMPARE_EN
      bus_a.expected_in = 4'($urandom);
      bus_a.mask_in     = 4'($urandom);
`endif
      exp_se   = (k <= NA) || (k > NA + CA && k <= 2 * NA + CA);
      exp_si   = 1'b0;
      if (k <= NA) begin
        exp_si = si_sh[3];
        si_sh  = si_sh << 1;
      end
      exp_busy = (k <= DoneA);
      exp_done = (k == DoneA);
      exp_r    = (k >= DoneA) ? exp_resp : last_resp_a;
      if (bus_a.done === 1'b1) done_cnt++;
      checks++;
      if (bus_a.SE !== exp_se) begin
        errors++;
        $display("FAIL %s SE cycle %0d: got %b want %b", name, k, bus_a.SE, exp_se);
      end
      checks++;
      if (bus_a.SI !== exp_si) begin
        errors++;
        $display("FAIL %s SI cycle %0d: got %b want %b", name, k, bus_a.SI, exp_si);
      end
      checks++;
      if (bus_a.busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, bus_a.busy, exp_busy);
      end
      checks++;
      if (bus_a.done !== exp_done) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, k, bus_a.done, exp_done);
      end
      checks++;
      if (bus_a.response_out !== exp_r) begin
        errors++;
        $display("FAIL %s response cycle %0d: got %b want %b", name, k, bus_a.response_out,
                 exp_r);
      end
`ifdef SCAN_CTRL_COMPARE_EN
      begin
        logic exp_f;
        exp_f = (k >= DoneA) ? |((exp_resp ^ cmp_exp) & ~cmp_mask) : last_fail_a;
        checks++;
        if (bus_a.fail !== exp_f) begin
          errors++;
          $display("FAIL %s fail cycle %0d: got %b want %b", name, k, bus_a.fail, exp_f);
        end
      end
`endif
      if (k <= DoneA) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
    last_resp_a = exp_resp;
`ifdef SCAN_CTRL_COMPARE_EN
    last_fail_a = |((exp_resp ^ cmp_exp) & ~cmp_mask);
`endif
  endtask

  task automatic test_reset();
    r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_a.SE, bus_a.SI, bus_a.busy, bus_a.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000", {bus_a.SE, bus_a.SI, bus_a.busy, bus_a.done});
    end
    checks++;
    if (bus_a.response_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_resp: got %b want 0000", bus_a.response_out);
    end
    checks++;
    if ({bus_b.busy, bus_c.busy, bus_b.done, bus_c.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_variants: got %b want 0000",
               {bus_b.busy, bus_c.busy, bus_b.done, bus_c.done});
    end
`ifdef SCAN_CTRL_COMPARE_EN
    checks++;
    if (bus_a.fail !== 1'b0) begin
      errors++;
      $display("FAIL reset_fail: got %b want 0", bus_a.fail);
    end
`endif
    @(negedge clk);
    r = 1'b1;
    last_resp_a = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bus_a.start      = 1'b1;
    bus_a.pattern_in = 4'($urandom);
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    r = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus_a.SE, bus_a.SI, bus_a.busy, bus_a.done} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_ctl: got %b want 0000", {bus_a.SE, bus_a.SI, bus_a.busy, bus_a.done});
    end
    checks++;
    if (bus_a.response_out !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_resp: got %b want 0000", bus_a.response_out);
    end
    last_resp_a = 4'b0000;
`ifdef SCAN_CTRL_COMPARE_EN
    last_fail_a = 1'b0;
    cmp_exp     = 4'b1110;
    cmp_mask    = 4'b0000;
`endif
    @(negedge clk);
    r = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d active cycles want 0", dones);
    end
    run_a(4'b0001, -1, 4'b0000, "after_reset");
  endtask

  task automatic test_basic();
`ifdef SCAN_CTRL_COMPARE_EN
    cmp_exp  = 4'b0100;
    cmp_mask = 4'b0000;
`endif
    run_a(4'b1011, -1, 4'b0000, "basic");
  endtask

  task automatic test_busy_start_and_back_to_back();
    run_a(4'b1011, 5, 4'b1111, "busy_start");
    run_a(4'b0000, -1, 4'b0000, "back_to_back");
  endtask

`ifdef SCAN_CTRL_COMPARE_EN
  task automatic test_compare();
    cmp_exp  = 4'b0110;
    cmp_mask = 4'b0000;
    run_a(4'b1011, -1, 4'b0000, "cmp_mismatch");
    cmp_mask = 4'b0010;
    run_a(4'b1011, -1, 4'b0000, "cmp_masked");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int extra;
      extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DoneA)) : -1;
`ifdef SCAN_CTRL_COMPARE_EN
      cmp_exp  = 4'($urandom);
      cmp_mask = 4'($urandom);
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_a(4'($urandom), extra, 4'($urandom), "random");
    end
  endtask

  task automatic test_capture3();
    logic [3:0] p;
    int         done_k;
    p      = 4'($urandom);
    done_k = 0;
    @(negedge clk);
    bus_b.start      = 1'b1;
    bus_b.pattern_in = p;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_b.done === 1'b1) begin
        done_k = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_k != DoneB) begin
      errors++;
      $display("FAIL capture3_latency: got %0d want %0d", done_k, DoneB);
    end
    checks++;
    if (bus_b.response_out !== ~p) begin
      errors++;
      $display("FAIL capture3_resp: got %b want %b", bus_b.response_out, ~p);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus_b.busy !== 1'b0) begin
      errors++;
      $display("FAIL capture3_busy_after: got %b want 0", bus_b.busy);
    end
  endtask

  task automatic test_len1();
    logic p;
    int   done_k;
    p      = 1'($urandom);
    done_k = 0;
    @(negedge clk);
    bus_c.start      = 1'b1;
    bus_c.pattern_in = p;
    @(posedge clk);
    #1;
    bus_c.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_c.done === 1'b1) begin
        done_k = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_k != DoneC) begin
      errors++;
      $display("FAIL len1_latency: got %0d want %0d", done_k, DoneC);
    end
    checks++;
    if (bus_c.response_out !== ~p) begin
      errors++;
      $display("FAIL len1_resp: got %b want %b", bus_c.response_out, ~p);
    end
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.pattern_in = 4'b0000;
    bus_b.start = 1'b0;
    bus_b.pattern_in = 4'b0000;
    bus_c.start = 1'b0;
    bus_c.pattern_in = 1'b0;
`ifdef SCAN_CTRL_COMPARE_EN
    bus_a.expected_in = 4'b0000;
    bus_a.mask_in = 4'b0000;
    bus_b.expected_in = 4'b0000;
    bus_b.mask_in = 4'b0000;
    bus_c.expected_in = 1'b0;
    bus_c.mask_in = 1'b0;
`endif
    test_reset();
    test_basic();
    test_busy_start_and_back_to_back();
`ifdef SCAN_CTRL_COMPARE_EN
    test_compare();
`endif
    test_reset_mid();
    test_random();
    test_capture3();
    test_len1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Sequencer that drives a serial chain of CHAIN_LEN scan D flip-flops (sdff cells joined Q-to-SI) through one full test cycle: shift-in, capture, shift-out. It generates the chain's shared SE and the head cell's SI, and samples the tail cell's Q (SO). It sits between a test-pattern source and the sdff chain, and returns the captured response as a parallel word.

Parameters:
CHAIN_LEN, 8, number of sdff cells in the chain (1 or more); cell 0 is the head (fed by SI), cell CHAIN_LEN-1 is the tail (drives SO).
CAPTURE_CYC, 1, number of functional-capture cycles with SE=0 (1 or more).

Ports:
CLK  input  1  clock; all logic updates on the rising edge.
R  input  1  reset; synchronous, active-low.
start  input  1  begin one test cycle; honoured only in IDLE.
pattern_in  input  CHAIN_LEN  stimulus; bit i is loaded into cell i.
SO  input  1  tail-cell Q of the chain.
SE  output  1  scan enable to all cells; registered.
SI  output  1  serial data to the head cell; registered.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when the response is valid.
response_out  output  CHAIN_LEN  captured value; bit i is cell i after capture.

Behaviour:
- Reset (R=0 at an edge): state=IDLE, SE=0, SI=0, busy=0, done=0, response_out=0, counters=0. This applies mid-operation too. The chain contents are then undefined and the controller does not scrub them.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: SE=0, SI=0. start=1 latches pattern_in into a shadow register and moves to SHIFT_IN. pattern_in changes after that edge have no effect.
- SHIFT_IN: SE=1 for exactly CHAIN_LEN consecutive cycles. SI carries shadow[CHAIN_LEN-1] in the first cycle, then descending indices, and shadow[0] in the last. After the final shift edge, cell i holds pattern_in[i].
- CAPTURE: SE=0 and SI=0 for exactly CAPTURE_CYC cycles. The cells load their functional D.
- SHIFT_OUT: SE=1 and SI=0 (zero fill) for exactly CHAIN_LEN cycles. SO is sampled on each of these rising edges, before the chain shifts. Sample k (k=0 first) is written to response bit CHAIN_LEN-1-k.
- DONE: one cycle. SE=0, done=1, response_out updated. The next state is IDLE.
- Latency: with the start edge at cycle 0, SE=1 during cycles 1..N, SE=0 during N+1..N+C, SE=1 during N+C+1..2N+C, and done=1 in cycle 2N+C+1 (N=CHAIN_LEN, C=CAPTURE_CYC). Total = 2N+C+1 cycles.
- busy=1 from cycle 1 through the DONE cycle inclusive. It is 0 in the cycle after done.
- start while busy: ignored, with no queueing. start in the cycle after DONE (already back in IDLE) is accepted, so back-to-back tests are allowed.
- response_out holds its value from DONE until the next DONE or reset. It does not change during a later test.
- Bit counter width is $clog2(CHAIN_LEN+1), minimum 1. CHAIN_LEN=1 gives 1 shift-in cycle and 1 shift-out cycle.
- The capture counter saturates at CAPTURE_CYC and never wraps.

Optional Feature:
Macro SCAN_CTRL_COMPARE_EN.
- Defined: adds inputs expected_in[CHAIN_LEN] and mask_in[CHAIN_LEN], both latched with start, and output fail (1 bit, registered).
  - fail is updated in the DONE cycle: fail = |((response ^ expected) & ~mask), where mask bit 1 means don't-care.
  - fail holds until the next DONE. Reset value is 0.
- Undefined: these ports and all compare logic are absent, and all other behaviour is identical.

Test Plan:
- Bench setup: CHAIN_LEN=4, CAPTURE_CYC=1, four sdff cells with each cell's D tied to the inverse of its own Q.
- Basic run: pulse start with pattern_in=4'b1011 -> SI sequence 1,0,1,1 in cycles 1-4. SE pattern 1111 0 1111. done in cycle 10. response_out=4'b0100. busy=0 in cycle 11.
- Reset mid-shift: start, then R=0 in cycle 3 -> SE=0, busy=0, response_out=0 next cycle. No done pulse. A fresh start with 4'b0001 then yields response 4'b1110.
- Start while busy: pulse start again in cycle 5 with pattern_in=4'b1111 -> ignored. Result is still 4'b0100, and only one done pulse occurs.
- Back-to-back: assert start in cycle 11 with 4'b0000 -> accepted. done in cycle 21. response_out=4'b1111, and it stays 4'b0100 through cycle 20.
- CAPTURE_CYC=3 and CHAIN_LEN=1 variants: done exactly at 2N+C+1 (cycles 12 and 4 respectively).
- With SCAN_CTRL_COMPARE_EN defined:
  - expected 4'b0100 -> fail=0.
  - expected 4'b0110, mask 0 -> fail=1.
  - expected 4'b0110, mask 4'b0010 -> fail=0.
